// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and flag helpers for the sequential ALU/MDU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULLU = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow of a+b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of a-b: operands differ in sign, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide, one step per cycle.
// For multiply hi/lo hold the running product (lo starts as the multiplier);
// for divide hi is the partial remainder and lo shifts the dividend out / quotient in.
module alu_muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  step_i,
    input  logic                  abort_i,
    input  logic                  is_div_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] lo_o,
    output logic [DATA_WIDTH-1:0] hi_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [DATA_WIDTH-1:0] hi_d, lo_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  is_div_q;
    logic [DATA_WIDTH:0]   add_s, shl_s, sub_s;

    // One multiply or divide step computed from the current state.
    always_comb begin
        add_s = {1'b0, hi_q} + {1'b0, opnd_q};
        shl_s = {hi_q, lo_q[DATA_WIDTH-1]};
        sub_s = shl_s - {1'b0, opnd_q};
        if (is_div_q) begin
            if (sub_s[DATA_WIDTH]) begin
                hi_d = shl_s[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                hi_d = sub_s[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
            end
        end else begin
            if (lo_q[0]) begin
                hi_d = add_s[DATA_WIDTH:1];
                lo_d = {add_s[0], lo_q[DATA_WIDTH-1:1]};
            end else begin
                hi_d = {1'b0, hi_q[DATA_WIDTH-1:1]};
                lo_d = {hi_q[0], lo_q[DATA_WIDTH-1:1]};
            end
        end
    end

    // Operand latch on start, then one step per cycle while stepping is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= {DATA_WIDTH{1'b0}};
            lo_q     <= {DATA_WIDTH{1'b0}};
            opnd_q   <= {DATA_WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
        end else if (abort_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (start_i) begin
            hi_q     <= {DATA_WIDTH{1'b0}};
            lo_q     <= is_div_i ? a_i : b_i;
            opnd_q   <= is_div_i ? b_i : a_i;
            cnt_q    <= {CNT_W{1'b0}};
            is_div_q <= is_div_i;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= (cnt_q == LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        end
    end

    // The final step's values are presented directly so the caller can register them on that edge.
    assign done_o = step_i && (cnt_q == LAST);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_seq_mdu.sv
// Handshaked ALU with single-cycle logic/arith ops and iterative unsigned mul/div/rem.
module alu_seq_mdu #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    zero_flag,
    output logic                    overflow_flag,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    busy
);
    import alu_pkg::*;

    state_t                  state_q;
    logic                    out_valid_q, zero_q, ovf_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [TAG_WIDTH-1:0]    tag_q, pend_tag_q;
    logic [3:0]              op_q;

    logic [DATA_WIDTH-1:0]   sum_s, diff_s, sc_res_s, it_res_s, md_lo_s, md_hi_s;
    logic                    sc_ovf_s, sc_legal_s, start_iter_s, it_ovf_s;
    logic                    b_zero_s, xfer_in_s, md_done_s;

    assign sum_s    = operand_a + operand_b;
    assign diff_s   = operand_a - operand_b;
    assign b_zero_s = (operand_b == {DATA_WIDTH{1'b0}});
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    // flush wins over a same-cycle request.
    assign xfer_in_s = in_valid && in_ready && !flush;

    // Single-cycle result/flags and detection of ops that must iterate.
    always_comb begin
        sc_res_s     = {DATA_WIDTH{1'b0}};
        sc_ovf_s     = 1'b0;
        sc_legal_s   = 1'b1;
        start_iter_s = 1'b0;
        case (alu_op)
            OP_AND: sc_res_s = operand_a & operand_b;
            OP_OR:  sc_res_s = operand_a | operand_b;
            OP_XOR: sc_res_s = operand_a ^ operand_b;
            OP_NOR: sc_res_s = ~(operand_a | operand_b);
            OP_ADD: begin
                sc_res_s = sum_s;
                sc_ovf_s = add_ovf(operand_a[DATA_WIDTH-1], operand_b[DATA_WIDTH-1], sum_s[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = diff_s;
                sc_ovf_s = sub_ovf(operand_a[DATA_WIDTH-1], operand_b[DATA_WIDTH-1], diff_s[DATA_WIDTH-1]);
            end
            OP_SLT: sc_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_MULLU, OP_MULHU: start_iter_s = 1'b1;
            OP_DIVU: begin
                if (b_zero_s) begin
                    sc_res_s = {DATA_WIDTH{1'b1}};
                    sc_ovf_s = 1'b1;
                end else begin
                    start_iter_s = 1'b1;
                end
            end
            OP_REMU: begin
                if (b_zero_s) begin
                    sc_res_s = operand_a;
                    sc_ovf_s = 1'b1;
                end else begin
                    start_iter_s = 1'b1;
                end
            end
            default: sc_legal_s = 1'b0;
        endcase
    end

    // Select the iterative result half for the op latched at acceptance.
    always_comb begin
        it_res_s = {DATA_WIDTH{1'b0}};
        it_ovf_s = 1'b0;
        case (op_q)
            OP_MULLU: begin
                it_res_s = md_lo_s;
                it_ovf_s = (md_hi_s != {DATA_WIDTH{1'b0}});
            end
            OP_MULHU: it_res_s = md_hi_s;
            OP_DIVU:  it_res_s = md_lo_s;
            OP_REMU:  it_res_s = md_hi_s;
            default:  it_res_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    alu_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (xfer_in_s && start_iter_s),
        .step_i   (state_q == ST_CALC),
        .abort_i  (flush),
        .is_div_i ((alu_op == OP_DIVU) || (alu_op == OP_REMU)),
        .a_i      (operand_a),
        .b_i      (operand_b),
        .done_o   (md_done_s),
        .lo_o     (md_lo_s),
        .hi_o     (md_hi_s)
    );

    // Handshake FSM; result, flags and tag are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {DATA_WIDTH{1'b0}};
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tag_q       <= {TAG_WIDTH{1'b0}};
            pend_tag_q  <= {TAG_WIDTH{1'b0}};
            op_q        <= OP_AND;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (xfer_in_s) begin
                        if (start_iter_s) begin
                            state_q     <= ST_CALC;
                            out_valid_q <= 1'b0;
                            op_q        <= alu_op;
                            pend_tag_q  <= in_tag;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_res_s;
                            zero_q      <= sc_legal_s && (sc_res_s == {DATA_WIDTH{1'b0}});
                            ovf_q       <= sc_ovf_s;
                            tag_q       <= in_tag;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (md_done_s) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= it_res_s;
                        zero_q      <= (it_res_s == {DATA_WIDTH{1'b0}});
                        ovf_q       <= it_ovf_s;
                        tag_q       <= pend_tag_q;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = result_q;
    assign zero_flag     = zero_q;
    assign overflow_flag = ovf_q;
    assign out_tag       = tag_q;
    assign busy          = (state_q == ST_CALC);

endmodule
